reorder_buffer: RTL and testbench

//  Circular reorder buffer for the Tomasulo core; the other end of the reservation station's rob interface.

---
 rtl/reorder_buffer_if.sv | 65 ++++++
 rtl/reorder_buffer.sv | 194 +++++++++++++++++++
 tb/tb_reorder_buffer.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reorder_buffer_if.sv
// reorder_buffer_if
//   Bundles the issue, operand-query, CDB and commit/flush signals that connect
//   the reorder buffer to the rest of the Tomasulo core.
//   master : core side (decoder, rename table, CDB arbiter, regfile).
//            Drives issue/query/CDB and receives the ROB's answers.
//   slave  : the reorder buffer itself.
//   Signals
//     issue_valid/rd/pc/branch/pred  new instruction from the decoder
//     is_full, new_tag               allocation status, tag for this issue
//     query_tag1/2 -> ready1/2, res1/2  operand lookups
//     cdb_valid/tag/val/taken/target    result broadcast
//     commit_valid/we/rd/val/tag        in-order retirement to the regfile
//     flush_out, redirect_pc            mispredict squash and new fetch PC
interface reorder_buffer_if #(
    parameter int ID_WIDTH   = 5,
    parameter int VAL_WIDTH  = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  issue_valid;
    logic [4:0]            issue_rd;
    logic [ADDR_WIDTH-1:0] issue_pc;
    logic                  issue_branch;
    logic                  issue_pred;
    logic                  is_full;
    logic [ID_WIDTH-1:0]   new_tag;

    logic [ID_WIDTH-1:0]   query_tag1;
    logic [ID_WIDTH-1:0]   query_tag2;
    logic                  ready1;
    logic                  ready2;
    logic [VAL_WIDTH-1:0]  res1;
    logic [VAL_WIDTH-1:0]  res2;

    logic                  cdb_valid;
    logic [ID_WIDTH-1:0]   cdb_tag;
    logic [VAL_WIDTH-1:0]  cdb_val;
    logic                  cdb_taken;
    logic [ADDR_WIDTH-1:0] cdb_target;

    logic                  commit_valid;
    logic                  commit_we;
    logic [4:0]            commit_rd;
    logic [VAL_WIDTH-1:0]  commit_val;
    logic [ID_WIDTH-1:0]   commit_tag;
    logic                  flush_out;
    logic [ADDR_WIDTH-1:0] redirect_pc;

    modport master (
        output issue_valid, issue_rd, issue_pc, issue_branch, issue_pred,
        output query_tag1, query_tag2,
        output cdb_valid, cdb_tag, cdb_val, cdb_taken, cdb_target,
        input  is_full, new_tag, ready1, ready2, res1, res2,
        input  commit_valid, commit_we, commit_rd, commit_val, commit_tag,
        input  flush_out, redirect_pc
    );

    modport slave (
        input  issue_valid, issue_rd, issue_pc, issue_branch, issue_pred,
        input  query_tag1, query_tag2,
        input  cdb_valid, cdb_tag, cdb_val, cdb_taken, cdb_target,
        output is_full, new_tag, ready1, ready2, res1, res2,
        output commit_valid, commit_we, commit_rd, commit_val, commit_tag,
        output flush_out, redirect_pc
    );
endinterface

// File: rtl/reorder_buffer.sv
// reorder_buffer
//   Circular reorder buffer for the Tomasulo core. Allocates tags at issue,
//   answers operand queries, captures CDB results, and retires entries in
//   program order. A mispredicted branch at the head raises a one-cycle flush
//   with the corrected fetch PC and empties the buffer.
//   Ports
//     clk     clock
//     rst_in  asynchronous, active-high reset
//     rdy_in  global enable; low freezes all state
//     rob     reorder_buffer_if.slave bundle (issue, query, CDB, commit, flush)
//   Tag encoding: tag = slot index + 1, so tag 0 always means "no dependency".
module reorder_buffer #(
    parameter int ROB_SIZE   = 16,
    parameter int ID_WIDTH   = 5,
    parameter int VAL_WIDTH  = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst_in,
    input  logic              rdy_in,
    reorder_buffer_if.slave   rob
);
    localparam int IDX_W = $clog2(ROB_SIZE);
    localparam int CNT_W = IDX_W + 1;

    localparam logic [1:0] ST_EMPTY   = 2'd0;
    localparam logic [1:0] ST_PENDING = 2'd1;
    localparam logic [1:0] ST_DONE    = 2'd2;

    // Per-slot lifecycle; the only storage that must be cleared on reset/flush.
    logic [1:0]            state   [ROB_SIZE];
    // Per-slot payload.
    logic [4:0]            rd_q    [ROB_SIZE];
    logic [ADDR_WIDTH-1:0] pc_q    [ROB_SIZE];
    logic                  br_q    [ROB_SIZE];
    logic                  pred_q  [ROB_SIZE];
    logic [VAL_WIDTH-1:0]  val_q   [ROB_SIZE];
    logic                  taken_q [ROB_SIZE];
    logic [ADDR_WIDTH-1:0] tgt_q   [ROB_SIZE];

    logic [IDX_W-1:0]      head;
    logic [IDX_W-1:0]      tail;
    logic [CNT_W-1:0]      count;

    logic                  commit_valid_q;
    logic                  commit_we_q;
    logic [4:0]            commit_rd_q;
    logic [VAL_WIDTH-1:0]  commit_val_q;
    logic [ID_WIDTH-1:0]   commit_tag_q;
    logic                  flush_q;
    logic [ADDR_WIDTH-1:0] redirect_q;

    function automatic logic tag_in_range(input logic [ID_WIDTH-1:0] tag);
        return (tag != '0) && (tag <= ID_WIDTH'(ROB_SIZE));
    endfunction

    function automatic logic [IDX_W-1:0] slot_of(input logic [ID_WIDTH-1:0] tag);
        return IDX_W'(tag - ID_WIDTH'(1));
    endfunction

    // ---------------------------------------------------------------
    // Control decisions for this edge
    // ---------------------------------------------------------------
    logic             issue_fire;
    logic             cdb_fire;
    logic             commit_fire;
    logic             mispredict;
    logic [IDX_W-1:0] cdb_idx;

    // Fullness comes from the registered count only, so a slot freed by a
    // commit at this edge is not reusable until the next cycle.
    assign rob.is_full = (count == CNT_W'(ROB_SIZE));
    assign rob.new_tag = ID_WIDTH'(tail) + ID_WIDTH'(1);

    // Issue and CDB inputs seen during a flush cycle belong to squashed work.
    assign issue_fire  = rob.issue_valid && !rob.is_full && rdy_in && !flush_q;
    assign cdb_idx     = slot_of(rob.cdb_tag);
    assign cdb_fire    = rob.cdb_valid && rdy_in && !flush_q &&
                         tag_in_range(rob.cdb_tag) && (state[cdb_idx] == ST_PENDING);
    assign commit_fire = rdy_in && (state[head] == ST_DONE);
    assign mispredict  = commit_fire && br_q[head] && (taken_q[head] != pred_q[head]);

    // ---------------------------------------------------------------
    // Operand queries, with same-cycle CDB bypass for pending slots
    // ---------------------------------------------------------------
    logic [ID_WIDTH-1:0]  q_tag   [2];
    logic                 q_ready [2];
    logic [VAL_WIDTH-1:0] q_res   [2];

    assign q_tag[0] = rob.query_tag1;
    assign q_tag[1] = rob.query_tag2;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            // NOTE: every output gets a default before the ifs so no path leaves it unassigned (no latch).
            q_ready[p] = 1'b0;
            q_res[p]   = '0;
            if (tag_in_range(q_tag[p])) begin
                if (state[slot_of(q_tag[p])] == ST_DONE) begin
                    q_ready[p] = 1'b1;
                    q_res[p]   = val_q[slot_of(q_tag[p])];
                end else if (state[slot_of(q_tag[p])] == ST_PENDING &&
                             rob.cdb_valid && rob.cdb_tag == q_tag[p]) begin
                    q_ready[p] = 1'b1;
                    q_res[p]   = rob.cdb_val;
                end
            end
        end
    end

    assign rob.ready1 = q_ready[0];
    assign rob.res1   = q_res[0];
    assign rob.ready2 = q_ready[1];
    assign rob.res2   = q_res[1];

    // ---------------------------------------------------------------
    // Pointers, slot states and registered commit/flush outputs
    // ---------------------------------------------------------------
    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            head           <= '0;
            tail           <= '0;
            count          <= '0;
            commit_valid_q <= 1'b0;
            commit_we_q    <= 1'b0;
            commit_rd_q    <= '0;
            commit_val_q   <= '0;
            commit_tag_q   <= '0;
            flush_q        <= 1'b0;
            redirect_q     <= '0;
            for (int i = 0; i < ROB_SIZE; i++) state[i] <= ST_EMPTY;
        end else if (!rdy_in) begin
            // Frozen: only the single-cycle pulses drop.
            commit_valid_q <= 1'b0;
            commit_we_q    <= 1'b0;
            flush_q        <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every read above sees pre-edge state.
            commit_valid_q <= commit_fire;
            commit_we_q    <= commit_fire && (rd_q[head] != 5'd0) && !br_q[head];
            flush_q        <= mispredict;
            if (commit_fire) begin
                commit_rd_q  <= rd_q[head];
                commit_val_q <= val_q[head];
                commit_tag_q <= ID_WIDTH'(head) + ID_WIDTH'(1);
            end
            if (mispredict) begin
                // Everything behind the branch is wrong-path work, including
                // anything issued this same cycle.
                redirect_q <= taken_q[head] ? tgt_q[head] : pc_q[head] + ADDR_WIDTH'(4);
                head       <= '0;
                tail       <= '0;
                count      <= '0;
                for (int i = 0; i < ROB_SIZE; i++) state[i] <= ST_EMPTY;
            end else begin
                // Commit, CDB and issue always target distinct slots: the head is
                // DONE, the CDB slot is PENDING, and the tail is EMPTY.
                if (commit_fire) begin
                    state[head] <= ST_EMPTY;
                    head        <= head + IDX_W'(1);
                end
                if (cdb_fire) state[cdb_idx] <= ST_DONE;
                if (issue_fire) begin
                    state[tail] <= ST_PENDING;
                    tail        <= tail + IDX_W'(1);
                end
                count <= count + CNT_W'(issue_fire) - CNT_W'(commit_fire);
            end
        end
    end

    // NOTE: payload arrays carry no reset; a slot's contents are only read once its state says they were written.
    always_ff @(posedge clk) begin
        if (issue_fire) begin
            rd_q[tail]   <= rob.issue_rd;
            pc_q[tail]   <= rob.issue_pc;
            br_q[tail]   <= rob.issue_branch;
            pred_q[tail] <= rob.issue_pred;
        end
        if (cdb_fire) begin
            val_q[cdb_idx]   <= rob.cdb_val;
            taken_q[cdb_idx] <= rob.cdb_taken;
            tgt_q[cdb_idx]   <= rob.cdb_target;
        end
    end

    assign rob.commit_valid = commit_valid_q;
    assign rob.commit_we    = commit_we_q;
    assign rob.commit_rd    = commit_rd_q;
    assign rob.commit_val   = commit_val_q;
    assign rob.commit_tag   = commit_tag_q;
    assign rob.flush_out    = flush_q;
    assign rob.redirect_pc  = redirect_q;
endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer
//   Directed bench for reorder_buffer. A queue-based program-order model
//   predicts every output; one compare process checks it on each falling
//   edge, and literal expectations along the directed sequence pin the model.
module tb_reorder_buffer;
    logic clk;
    logic rst_in;
    logic rdy_in;
    reorder_buffer_if rob_bus ();

    reorder_buffer dut (
        .clk    (clk),
        .rst_in (rst_in),
        .rdy_in (rdy_in),
        .rob    (rob_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    bit cmp_en = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- model: entries in program order ----------------
    typedef struct {
        int          tag;
        logic [4:0]  rd;
        logic [31:0] pc;
        bit          br;
        bit          pred;
        bit          done;
        logic [31:0] val;
        bit          taken;
        logic [31:0] tgt;
    } ent_t;

    ent_t        q[$];
    int          next_tag;
    bit          m_cv, m_cwe, m_flush;
    logic [4:0]  m_crd;
    logic [31:0] m_cval, m_redir;
    int          m_ctag;

    function automatic void model_reset();
        q.delete();
        next_tag = 1;
        m_cv = 0; m_cwe = 0; m_flush = 0;
        m_crd = 0; m_cval = 0; m_ctag = 0; m_redir = 0;
    endfunction

    function automatic void model_step();
        bit full, stale, mis;
        ent_t e;
        if (!rdy_in) begin
            m_cv = 0; m_cwe = 0; m_flush = 0;
            return;
        end
        full  = (q.size() == 16);
        stale = m_flush;
        mis   = 0;
        if (q.size() > 0 && q[0].done) begin
            e      = q.pop_front();
            m_cv   = 1;
            m_cwe  = (e.rd != 0) && !e.br;
            m_crd  = e.rd;
            m_cval = e.val;
            m_ctag = e.tag;
            mis    = e.br && (e.taken != e.pred);
            if (mis) m_redir = e.taken ? e.tgt : e.pc + 32'd4;
        end else begin
            m_cv = 0; m_cwe = 0;
        end
        m_flush = mis;
        if (mis) begin
            q.delete();
            next_tag = 1;
            return;
        end
        if (!stale && rob_bus.cdb_valid) begin
            foreach (q[i]) begin
                if (q[i].tag == int'(rob_bus.cdb_tag) && !q[i].done) begin
                    q[i].done  = 1;
                    q[i].val   = rob_bus.cdb_val;
                    q[i].taken = rob_bus.cdb_taken;
                    q[i].tgt   = rob_bus.cdb_target;
                end
            end
        end
        if (!stale && rob_bus.issue_valid && !full) begin
            e = '{tag: next_tag, rd: rob_bus.issue_rd, pc: rob_bus.issue_pc,
                  br: rob_bus.issue_branch, pred: rob_bus.issue_pred,
                  done: 0, val: 0, taken: 0, tgt: 0};
            q.push_back(e);
            next_tag = (next_tag == 16) ? 1 : next_tag + 1;
        end
    endfunction

    function automatic void model_query(input logic [4:0] t, output bit r, output logic [31:0] v);
        r = 0;
        v = 0;
        if (t == 0) return;
        foreach (q[i]) begin
            if (q[i].tag == int'(t)) begin
                if (q[i].done) begin
                    r = 1; v = q[i].val;
                end else if (rob_bus.cdb_valid && rob_bus.cdb_tag == t) begin
                    r = 1; v = rob_bus.cdb_val;
                end
            end
        end
    endfunction

    always @(posedge clk) if (!rst_in) model_step();

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin : compare
        bit          r;
        logic [31:0] v;
        if (cmp_en && !rst_in) begin
            check("is_full", rob_bus.is_full, q.size() == 16);
            check("new_tag", rob_bus.new_tag, next_tag);
            model_query(rob_bus.query_tag1, r, v);
            check("ready1", rob_bus.ready1, r);
            check("res1", rob_bus.res1, v);
            model_query(rob_bus.query_tag2, r, v);
            check("ready2", rob_bus.ready2, r);
            check("res2", rob_bus.res2, v);
            check("commit_valid", rob_bus.commit_valid, m_cv);
            if (m_cv) begin
                check("commit_we", rob_bus.commit_we, m_cwe);
                check("commit_rd", rob_bus.commit_rd, m_crd);
                check("commit_val", rob_bus.commit_val, m_cval);
                check("commit_tag", rob_bus.commit_tag, m_ctag);
            end
            check("flush_out", rob_bus.flush_out, m_flush);
            if (m_flush) check("redirect_pc", rob_bus.redirect_pc, m_redir);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rob_bus.issue_valid  = 0;
        rob_bus.issue_rd     = 0;
        rob_bus.issue_pc     = 0;
        rob_bus.issue_branch = 0;
        rob_bus.issue_pred   = 0;
        rob_bus.query_tag1   = 0;
        rob_bus.query_tag2   = 0;
        rob_bus.cdb_valid    = 0;
        rob_bus.cdb_tag      = 0;
        rob_bus.cdb_val      = 0;
        rob_bus.cdb_taken    = 0;
        rob_bus.cdb_target   = 0;
    endtask

    task automatic issue(input logic [4:0] rd, input logic [31:0] pc, input bit br, input bit pred);
        rob_bus.issue_valid  = 1;
        rob_bus.issue_rd     = rd;
        rob_bus.issue_pc     = pc;
        rob_bus.issue_branch = br;
        rob_bus.issue_pred   = pred;
    endtask

    task automatic cdb(input logic [4:0] tag, input logic [31:0] val, input bit taken, input logic [31:0] tgt);
        rob_bus.cdb_valid  = 1;
        rob_bus.cdb_tag    = tag;
        rob_bus.cdb_val    = val;
        rob_bus.cdb_taken  = taken;
        rob_bus.cdb_target = tgt;
    endtask

    task automatic do_reset();
        idle();
        rst_in = 1;
        model_reset();
        tick();
        tick();
        rst_in = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    // ---------------- directed sequence ----------------
    initial begin
        rst_in = 0;
        rdy_in = 1;
        idle();
        model_reset();
        #1 rst_in = 1;
        #1;
        check("rst_is_full", rob_bus.is_full, 0);
        check("rst_new_tag", rob_bus.new_tag, 1);
        check("rst_commit_valid", rob_bus.commit_valid, 0);
        check("rst_flush", rob_bus.flush_out, 0);
        cmp_en = 1;
        tick();
        rst_in = 0;

        // 1. three issues
        for (int i = 1; i <= 3; i++) begin
            issue(5'(i), 32'h10 * i, 0, 0);
            #1 check("t1_new_tag", rob_bus.new_tag, i);
            tick();
        end
        idle();
        #1;
        check("t1_new_tag_after", rob_bus.new_tag, 4);
        check("t1_not_full", rob_bus.is_full, 0);
        check("t1_no_commit", rob_bus.commit_valid, 0);

        // 2. out-of-order completion, in-order commit
        cdb(2, 32'h55, 0, 0);
        tick();
        idle();
        tick();
        check("t2_head_pending", rob_bus.commit_valid, 0);
        cdb(1, 32'h11, 0, 0);
        tick();
        idle();
        check("t2_latency", rob_bus.commit_valid, 0);
        tick();
        check("t2_c1_valid", rob_bus.commit_valid, 1);
        check("t2_c1_rd", rob_bus.commit_rd, 1);
        check("t2_c1_val", rob_bus.commit_val, 32'h11);
        check("t2_c1_tag", rob_bus.commit_tag, 1);
        tick();
        check("t2_c2_valid", rob_bus.commit_valid, 1);
        check("t2_c2_we", rob_bus.commit_we, 1);
        check("t2_c2_rd", rob_bus.commit_rd, 2);
        check("t2_c2_val", rob_bus.commit_val, 32'h55);
        check("t2_c2_tag", rob_bus.commit_tag, 2);

        // 3. query bypass, tag 0, DONE lookup
        rob_bus.query_tag1 = 3;
        rob_bus.query_tag2 = 0;
        cdb(3, 32'h7, 0, 0);
        #1;
        check("t3_bypass_ready", rob_bus.ready1, 1);
        check("t3_bypass_res", rob_bus.res1, 32'h7);
        check("t3_tag0_ready", rob_bus.ready2, 0);
        check("t3_tag0_res", rob_bus.res2, 0);
        tick();
        rob_bus.cdb_valid = 0;
        #1;
        check("t3_done_ready", rob_bus.ready1, 1);
        check("t3_done_res", rob_bus.res1, 32'h7);
        tick();
        check("t3_retired_ready", rob_bus.ready1, 0);
        idle();
        tick();

        // 4. fill, overflow, commit-while-full, tag wrap
        do_reset();
        for (int i = 0; i < 16; i++) begin
            issue(5'(i + 1), 32'h1000 + 32'(4 * i), 0, 0);
            tick();
        end
        idle();
        #1;
        check("t4_full", rob_bus.is_full, 1);
        check("t4_wrap_tag", rob_bus.new_tag, 1);
        issue(20, 32'h2000, 0, 0);
        tick();
        check("t4_17th_ignored", rob_bus.is_full, 1);
        cdb(1, 32'hAA, 0, 0);
        tick();
        rob_bus.cdb_valid = 0;
        check("t4_still_full", rob_bus.is_full, 1);
        tick();
        check("t4_commit_tag1", rob_bus.commit_tag, 1);
        check("t4_freed", rob_bus.is_full, 0);
        check("t4_realloc_tag", rob_bus.new_tag, 1);
        tick();
        check("t4_refull", rob_bus.is_full, 1);
        check("t4_next_tag", rob_bus.new_tag, 2);
        idle();
        cdb(5, 32'h55, 0, 0);
        tick();
        cdb(5, 32'h99, 0, 0);
        tick();
        cdb(0, 32'h33, 0, 0);
        tick();
        idle();
        rob_bus.query_tag1 = 5;
        rob_bus.query_tag2 = 6;
        #1;
        check("t4_done_kept", rob_bus.res1, 32'h55);
        check("t4_pending_ready", rob_bus.ready2, 0);
        idle();
        tick();

        // 5. branch mispredict flush, correct prediction, pc+4 redirect
        do_reset();
        issue(0, 32'h100, 1, 0);
        tick();
        issue(4, 32'h104, 0, 0);
        tick();
        issue(5, 32'h108, 0, 0);
        tick();
        idle();
        cdb(1, 32'h0, 1, 32'h200);
        tick();
        idle();
        tick();
        check("t5_flush", rob_bus.flush_out, 1);
        check("t5_redirect", rob_bus.redirect_pc, 32'h200);
        check("t5_br_commit", rob_bus.commit_valid, 1);
        check("t5_br_no_we", rob_bus.commit_we, 0);
        check("t5_new_tag", rob_bus.new_tag, 1);
        check("t5_empty", rob_bus.is_full, 0);
        issue(6, 32'h10C, 0, 0);
        cdb(2, 32'h66, 0, 0);
        rob_bus.query_tag1 = 2;
        #1 check("t5_squashed_query", rob_bus.ready1, 0);
        tick();
        idle();
        check("t5_flush_pulse", rob_bus.flush_out, 0);
        check("t5_stale_issue", rob_bus.new_tag, 1);
        issue(0, 32'h100, 1, 0);
        tick();
        issue(7, 32'h104, 0, 0);
        tick();
        idle();
        cdb(1, 32'h0, 0, 32'h200);
        tick();
        idle();
        tick();
        check("t5b_commit", rob_bus.commit_valid, 1);
        check("t5b_no_we", rob_bus.commit_we, 0);
        check("t5b_no_flush", rob_bus.flush_out, 0);
        check("t5b_new_tag", rob_bus.new_tag, 3);
        issue(0, 32'h300, 1, 1);
        tick();
        idle();
        cdb(2, 32'h22, 0, 0);
        tick();
        cdb(3, 32'h0, 0, 32'h400);
        tick();
        idle();
        tick();
        check("t5c_flush", rob_bus.flush_out, 1);
        check("t5c_redirect", rob_bus.redirect_pc, 32'h304);
        tick();

        // rdy_in low freezes
        issue(9, 32'h500, 0, 0);
        tick();
        idle();
        cdb(1, 32'h99, 0, 0);
        tick();
        idle();
        rdy_in = 0;
        issue(10, 32'h504, 0, 0);
        tick();
        tick();
        check("frz_no_commit", rob_bus.commit_valid, 0);
        check("frz_no_issue", rob_bus.new_tag, 2);
        rdy_in = 1;
        idle();
        tick();
        check("frz_resume", rob_bus.commit_valid, 1);
        check("frz_resume_val", rob_bus.commit_val, 32'h99);
        tick();

        // 6. asynchronous reset between edges with work in flight
        do_reset();
        for (int i = 0; i < 5; i++) begin
            issue(5'(i + 1), 32'h600 + 32'(4 * i), 0, 0);
            tick();
        end
        idle();
        cdb(1, 32'h5A, 0, 0);
        tick();
        idle();
        tick();
        check("t6_pre_commit", rob_bus.commit_valid, 1);
        check("t6_pre_val", rob_bus.commit_val, 32'h5A);
        #1;
        rst_in = 1;
        model_reset();
        #1;
        check("t6_commit_cleared", rob_bus.commit_valid, 0);
        check("t6_not_full", rob_bus.is_full, 0);
        check("t6_new_tag", rob_bus.new_tag, 1);
        check("t6_flush", rob_bus.flush_out, 0);
        tick();
        rst_in = 0;
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
